// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 data mux between four requesters, with
// bursts of up to MAX_HOLD beats per grant and a registered valid/ready output.
module mux_rr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   d,
    input  logic                  out_ready,
    output logic [3:0]            gnt,
    output logic [1:0]            sel,
    output logic [3:0]            ack,
    output logic [DATA_W-1:0]     q,
    output logic                  out_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_HOLD - 1);

    state_t              state_r, state_n;
    logic [1:0]          ptr_r, ptr_n;
    logic [3:0]          cnt_r, cnt_n;
    logic [3:0]          gnt_r, gnt_n;
    logic [1:0]          sel_r, sel_n;
    logic [DATA_W-1:0]   q_r;
    logic                out_valid_r;

    logic                space_s;
    logic                take_s;
    logic                last_beat_s;
    logic                release_s;
    logic [1:0]          win_s;
    logic [DATA_W-1:0]   lane_data_s;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // Scan from the highest offset down so the lane closest to ptr wins last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] pick;
        logic [1:0] cand;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            cand = p + 2'(k);
            if (r[cand]) begin
                pick = cand;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Handshake and beat-acceptance decode for the currently selected lane.
    always_comb begin
        space_s     = ~out_valid_r | out_ready;
        take_s      = (state_r == GRANT) & req[sel_r] & space_s;
        last_beat_s = (cnt_r == LAST_BEAT);
        release_s   = ~req[sel_r] | (take_s & last_beat_s);
        win_s       = rr_pick(req, ptr_r);
        lane_data_s = d[sel_r*DATA_W +: DATA_W];
        ack         = take_s ? onehot4(sel_r) : 4'b0000;
    end

    // Arbitration FSM: next state, grant, select, pointer and beat counter.
    always_comb begin
        state_n = state_r;
        ptr_n   = ptr_r;
        cnt_n   = cnt_r;
        gnt_n   = gnt_r;
        sel_n   = sel_r;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_n = GRANT;
                    gnt_n   = onehot4(win_s);
                    sel_n   = win_s;
                    cnt_n   = 4'd0;
                end else begin
                    gnt_n   = 4'b0000;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_n = IDLE;
                    gnt_n   = 4'b0000;
                    ptr_n   = sel_r + 2'd1;
                    cnt_n   = 4'd0;
                end else if (take_s) begin
                    cnt_n   = cnt_r + 4'd1;
                end else begin
                    cnt_n   = cnt_r;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= 2'd0;
            cnt_r   <= 4'd0;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
        end else begin
            state_r <= state_n;
            ptr_r   <= ptr_n;
            cnt_r   <= cnt_n;
            gnt_r   <= gnt_n;
            sel_r   <= sel_n;
        end
    end

    // Output stage: load on take (load-through allowed), drain on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r         <= '0;
            out_valid_r <= 1'b0;
        end else if (take_s) begin
            q_r         <= lane_data_s;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign gnt       = gnt_r;
    assign sel       = sel_r;
    assign q         = q_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: per-cycle comparison against a
// lane/owner-level model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_mux_rr_arbiter;

    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic [3:0]  req       = 4'b0000;
    logic [31:0] d         = 32'h0;
    logic        out_ready = 1'b0;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        out_valid;

    int tests  = 0;
    int failed = 0;

    mux_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .d(d), .out_ready(out_ready),
        .gnt(gnt), .sel(sel), .ack(ack), .q(q), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the mux (-1 = nobody), beats delivered, next-start lane.
    typedef struct packed {
        int         owner;
        int         beats;
        int         ptr;
        int         last_sel;
        logic [7:0] q;
        logic       v;
    } m_t;

    localparam m_t M_RESET = '{owner: -1, beats: 0, ptr: 0, last_sel: 0, q: 8'h00, v: 1'b0};
    m_t m = M_RESET;

    function automatic logic [7:0] lane(input logic [31:0] dd, input int i);
        return dd[i*8 +: 8];
    endfunction

    function automatic logic [3:0] exp_ack(input m_t s, input logic [3:0] r, input logic rdy);
        if (s.owner >= 0 && r[s.owner] && (!s.v || rdy)) return 4'(4'b0001 << s.owner);
        return 4'b0000;
    endfunction

    function automatic logic [3:0] exp_gnt(input m_t s);
        return (s.owner < 0) ? 4'b0000 : 4'(4'b0001 << s.owner);
    endfunction

    function automatic m_t model_next(input m_t s, input logic [3:0] r, input logic [31:0] dd, input logic rdy);
        m_t   n;
        logic took;
        int   cand;
        n    = s;
        took = (exp_ack(s, r, rdy) != 4'b0000);
        if (s.owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                cand = (s.ptr + k) % 4;
                if (r[cand] && n.owner < 0) begin
                    n.owner    = cand;
                    n.last_sel = cand;
                    n.beats    = 0;
                end
            end
        end else if (!r[s.owner] || (took && s.beats + 1 == MAX_HOLD)) begin
            n.ptr   = (s.owner + 1) % 4;
            n.owner = -1;
            n.beats = 0;
        end else if (took) begin
            n.beats = s.beats + 1;
        end
        if (took) begin
            n.q = lane(dd, s.owner);
            n.v = 1'b1;
        end else if (s.v && rdy) begin
            n.v = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= M_RESET;
        else        m <= model_next(m, req, d, out_ready);
    end

    // Per-cycle comparison, 2 time units after the falling edge.
    always @(negedge clk) begin
        #2;
        check("gnt",       32'(gnt),       32'(exp_gnt(m)));
        check("sel",       32'(sel),       32'(m.last_sel));
        check("ack",       32'(ack),       32'(exp_ack(m, req, out_ready)));
        check("out_valid", 32'(out_valid), 32'(m.v));
        check("q",         32'(q),         32'(m.q));
    end

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    initial begin
        logic [7:0] qlog[$];
        logic [3:0] glog[$];
        logic [3:0] prev_g;
        logic [7:0] grp_val[4];
        logic [3:0] t3_order[5];
        logic [3:0] t5_order[3];
        int         acks;
        int         done_i;
        int         a2;
        logic       raised0;

        #1 rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // All lanes requesting: grant order 0,1,2,3,0 and four beats per lane.
        d = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        out_ready = 1'b1;
        prev_g = 4'b0000;
        for (int i = 1; i <= 23; i++) begin
            tick();
            #1;
            if (out_valid && out_ready) qlog.push_back(q);
            if (gnt != 4'b0000 && prev_g == 4'b0000) glog.push_back(gnt);
            prev_g = gnt;
        end
        grp_val  = '{8'h10, 8'h11, 8'h12, 8'h13};
        t3_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check("t3_ngrants", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 5 && i < glog.size(); i++) check("t3_order", 32'(glog[i]), 32'(t3_order[i]));
        check("t3_nbeats", 32'(qlog.size()), 32'd18);
        for (int i = 0; i < 16 && i < qlog.size(); i++) check("t3_qseq", 32'(qlog[i]), 32'(grp_val[i/4]));

        // Asynchronous reset between clock edges while a beat is held.
        check("t1_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t1_gnt", 32'(gnt), 32'd0);
        check("t1_sel", 32'(sel), 32'd0);
        check("t1_q",   32'(q),   32'd0);
        check("t1_ov",  32'(out_valid), 32'd0);
        check("t1_ack", 32'(ack), 32'd0);
        req = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();

        // Single lane 1: four beats, one bubble, then re-grant.
        d = 32'h0000A500;
        req = 4'b0010;
        acks = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            #1;
            if (i <= 5 && ack == 4'b0010) acks++;
            if (i == 1) begin
                check("t2_gnt1", 32'(gnt), 32'h2);
                check("t2_sel1", 32'(sel), 32'd1);
            end
            if (i == 2) begin
                check("t2_q",  32'(q), 32'hA5);
                check("t2_ov", 32'(out_valid), 32'd1);
            end
            if (i == 5) check("t2_bubble", 32'(gnt), 32'h0);
            if (i == 6) begin
                check("t2_regrant", 32'(gnt), 32'h2);
                req = 4'b0000;
            end
        end
        check("t2_acks", 32'(acks), 32'd4);
        repeat (3) tick();

        // Backpressure on lane 0 after its first beat.
        d = 32'h00000077;
        req = 4'b0001;
        acks = 0;
        done_i = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 2) out_ready = 1'b0;
            if (i == 5) out_ready = 1'b1;
            #1;
            if (ack[0]) acks++;
            if (i == 4) begin
                check("t4_stall_ack", 32'(ack), 32'h0);
                check("t4_stall_ov",  32'(out_valid), 32'd1);
                check("t4_stall_q",   32'(q), 32'h77);
                check("t4_stall_gnt", 32'(gnt), 32'h1);
                check("t4_frozen",    32'(acks), 32'd1);
            end
            if (i > 1 && gnt == 4'b0000 && done_i == 0) begin
                done_i = i;
                req = 4'b0000;
            end
        end
        check("t4_acks",    32'(acks), 32'd4);
        check("t4_release", 32'(done_i), 32'd8);

        // Early drop of lane 2, then lane 3, then wrap to lane 0.
        d = {8'h33, 8'h22, 8'h00, 8'h44};
        req = 4'b1100;
        glog.delete();
        prev_g = 4'b0000;
        a2 = 0;
        raised0 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (a2 >= 2) req[2] = 1'b0;
            #1;
            if (ack[2]) a2++;
            if (gnt != 4'b0000 && prev_g == 4'b0000) glog.push_back(gnt);
            if (gnt == 4'b1000 && !raised0) begin
                req[0] = 1'b1;
                raised0 = 1'b1;
            end
            prev_g = gnt;
        end
        t5_order = '{4'b0100, 4'b1000, 4'b0001};
        check("t5_lane2_acks", 32'(a2), 32'd2);
        check("t5_ngrants", 32'(glog.size()), 32'd3);
        for (int i = 0; i < 3 && i < glog.size(); i++) check("t5_order", 32'(glog[i]), 32'(t5_order[i]));
        req = 4'b0000;
        repeat (6) tick();

        // Reset during beat 2 of lane 1, then lane 0 wins from ptr=0.
        d = 32'h00005A66;
        req = 4'b0010;
        tick();
        tick();
        #1;
        check("t6_pre_ack", 32'(ack), 32'h2);
        rst_n = 1'b0;
        #1;
        check("t6_gnt", 32'(gnt), 32'd0);
        check("t6_ov",  32'(out_valid), 32'd0);
        check("t6_q",   32'(q), 32'd0);
        check("t6_ack", 32'(ack), 32'd0);
        req = 4'b0011;
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        check("t6_first_gnt", 32'(gnt), 32'h1);
        check("t6_first_sel", 32'(sel), 32'd0);
        req = 4'b0000;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
